// File: rtl/song_recorder.sv
// Record-mode track capture: turns single key presses into {octave, note, length}
// entries in a small track memory, with a registered read port for replay.
module song_recorder #(
    parameter int DEPTH           = 32,
    parameter int CNT_BITS        = 6,
    parameter int NOTE_KEY_BITS   = 7,
    parameter int LENGTH_KEY_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clear,
    input  logic                       undo,
    input  logic                       oct_up,
    input  logic                       oct_down,
    input  logic                       rest_key,
    input  logic [NOTE_KEY_BITS-1:0]   note_key,
    input  logic [LENGTH_KEY_BITS-1:0] length_key,
    input  logic [CNT_BITS-1:0]        rd_addr,
    output logic [8:0]                 rd_data,
    output logic [CNT_BITS-1:0]        track,
    output logic [2:0]                 octave,
    output logic                       full,
    output logic                       wr_pulse,
    output logic                       err_pulse
);

    // state | meaning
    // IDLE  | record mode off
    // ARMED | all keys released, next press is recorded
    // HELD  | press consumed, waiting for every key to be released
    typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

    localparam int AW = $clog2(DEPTH);

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   track_q, track_d;
    logic [2:0]            octave_q, octave_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [8:0]            rd_data_q;
    logic [8:0]            mem_q [DEPTH];

    logic                  released;
    logic                  note_ok;
    logic                  len_ok;
    logic                  press_ok;
    logic                  wr_en;
    logic [2:0]            note_idx;
    logic [2:0]            len_idx;
    logic [8:0]            entry;

    assign full     = (track_q == CNT_BITS'(DEPTH));
    assign released = (note_key == '0) && !rest_key;

    always_comb begin
        note_idx = 3'd0;
        for (int i = 0; i < NOTE_KEY_BITS; i++) begin
            if (note_key[i]) note_idx = 3'(i + 1);
        end
        len_idx = 3'd2;
        for (int i = 0; i < LENGTH_KEY_BITS; i++) begin
            if (length_key[i]) len_idx = 3'(i + 1);
        end
        note_ok  = rest_key ? (note_key == '0) : $onehot(note_key);
        len_ok   = (length_key == '0) || $onehot(length_key);
        press_ok = note_ok && len_ok && !full;
        entry    = {octave_q, (rest_key ? 3'd0 : note_idx), len_idx};
    end

    always_comb begin
        state_d     = state_q;
        track_d     = track_q;
        octave_d    = octave_q;
        wr_pulse_d  = 1'b0;
        err_pulse_d = 1'b0;
        wr_en       = 1'b0;
        if (clear) begin
            track_d  = '0;
            octave_d = 3'd4;
            state_d  = en ? ARMED : IDLE;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            if (oct_up && !oct_down && octave_q != 3'd7) begin
                octave_d = octave_q + 3'd1;
            end else if (oct_down && !oct_up && octave_q != 3'd1) begin
                octave_d = octave_q - 3'd1;
            end
            if (undo && track_q != '0) track_d = track_q - CNT_BITS'(1);
            case (state_q)
                IDLE:  state_d = released ? ARMED : HELD;
                ARMED: begin
                    if (!released) begin
                        state_d = HELD;
                        // undo swallows a coincident press without recording or flagging it
                        if (!undo) begin
                            if (press_ok) begin
                                wr_en      = 1'b1;
                                wr_pulse_d = 1'b1;
                                track_d    = track_q + CNT_BITS'(1);
                            end else begin
                                err_pulse_d = 1'b1;
                            end
                        end
                    end
                end
                HELD:    if (released) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            track_q     <= '0;
            octave_q    <= 3'd4;
            wr_pulse_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            track_q     <= track_d;
            octave_q    <= octave_d;
            wr_pulse_q  <= wr_pulse_d;
            err_pulse_q <= err_pulse_d;
            rd_data_q   <= (rd_addr < track_q) ? mem_q[rd_addr[AW-1:0]] : '0;
        end
    end

    // Track memory is deliberately not reset; validity is tracked by track_q.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem_q[track_q[AW-1:0]] <= entry;
    end

    assign rd_data   = rd_data_q;
    assign track     = track_q;
    assign octave    = octave_q;
    assign wr_pulse  = wr_pulse_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: doc/song_recorder.md
# song_recorder

Record-mode counterpart to the play-mode datapath: where play mode reads a song track entry by entry and scores user hits against it, `song_recorder` captures the user's key presses (octave, note, length) and writes them as song entries into an internal track memory. A registered read port exposes the recorded track to the song/sound path, in the same entry format, so a recorded track can be replayed or used as a play-mode target. Sits beside play mode under the top-level mode selector and shares the note/length/octave keys with it.

## Interface
- DEPTH, 32, number of entries in the track memory
- CNT_BITS, 6, width of track count/address; 2^CNT_BITS > DEPTH required
- NOTE_KEY_BITS, 7, one-hot note keys (key i -> note i+1)
- LENGTH_KEY_BITS, 4, one-hot length keys (key i -> length i+1)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  record mode active
- clear  in  1  pulse: discard recorded track
- undo  in  1  pulse: remove last entry
- oct_up, oct_down  in  1 each  octave step pulses
- rest_key  in  1  record a rest (note 0)
- note_key  in  NOTE_KEY_BITS  note keys, level
- length_key  in  LENGTH_KEY_BITS  length keys, level
- rd_addr  in  CNT_BITS  read address
- rd_data  out  9  {octave[2:0], note[2:0], length[2:0]}, registered
- track  out  CNT_BITS  number of valid entries
- octave  out  3  current recording octave
- full  out  1  track == DEPTH
- wr_pulse  out  1  one cycle after each write
- err_pulse  out  1  one cycle after a rejected press

## Operation
- States: IDLE (en=0), ARMED (all keys released, waiting), HELD (press consumed, waiting for release).
- IDLE -> ARMED when en=1 and note_key==0 and rest_key==0; else IDLE -> HELD. Any state -> IDLE when en=0.
- Press event in ARMED: note_key exactly one-hot, or rest_key=1 with note_key==0. Entry = {octave, note, length}; note = key index+1, rest -> 0.
- length: length_key one-hot -> index+1; length_key==0 -> 2 (default quarter); multiple bits -> reject.
- Reject (multiple note keys, rest plus note key, multiple length keys, or full=1): no write, err_pulse, go HELD.
- Accepted press: mem[track] <= entry, track <= track+1, wr_pulse, go HELD.
- HELD -> ARMED when note_key==0 and rest_key==0.
- octave: range 1..7, reset/clear value 4; oct_up/oct_down saturate at 7/1; both high same cycle -> no change. Active only when en=1.
- undo (en=1): track <= track-1 if track>0, else no-op. undo has priority over a same-cycle press; that press is consumed (state HELD, no write, no err_pulse).
- clear (any state, any en): track<=0, octave<=4, state ARMED if en else IDLE; priority over undo and press.
- Same-cycle octave step and press: entry uses octave before the step.
- Memory contents are not reset; rd_data is 0 for rd_addr >= track.
- en low mid-HELD: no write; track, octave, memory retained.

## Timing
- Reset (rst_n=0 at edge): state IDLE, track=0, octave=4, full=0, wr_pulse=0, err_pulse=0, rd_data=0.
- Press sampled at edge N: mem and track updated at edge N; wr_pulse/err_pulse high during cycle N to N+1; full updates at edge N.
- rd_data latency 1 cycle: rd_addr at edge N -> rd_data valid after edge N; write at edge N to address A visible on rd_data for rd_addr=A after edge N+1.
- One write maximum per key press regardless of hold duration.

## Test plan
- Reset, en=1, note_key=7'b0000100, length_key=0 one cycle then release -> wr_pulse once, track=1, rd_addr=0 gives {4,3,2} = 9'b100_011_010.
- oct_up x4 then press key 0 with length_key=4'b1000 -> octave saturates at 7, entry {7,1,4}; oct_down x8 -> octave 1.
- Hold note_key for 100 cycles -> exactly one write; press two note keys -> err_pulse, track unchanged.
- Fill 32 entries -> full=1, 33rd press -> err_pulse, track stays 32; undo -> track 31, full=0.
- undo and press same cycle with track=5 -> track 4, no wr_pulse; clear -> track 0, octave 4, rd_data 0 for address 0.
- Drop en while key held, raise en with key still held -> no write until release and new press; rst_n=0 mid-record -> all outputs to reset values.
